// File: rtl/priority_encoder_8to3_reg.sv
// Registered 8-to-3 priority encoder. Requests are held in a sticky pending register
// and handed out one code at a time over a VALID/READY handshake.
module priority_encoder_8to3_reg #(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       EN,
   input  logic [7:0] D,
   input  logic       READY,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       VALID,
   output logic [7:0] PEND,
   output logic       EMPTY
);

   // Index of the winning request. The loop direction means the last match wins,
   // so scanning upward favours index 7 and scanning downward favours index 0.
   function automatic logic [2:0] sel_index(input logic [7:0] v, input bit lsb_first);
      logic [2:0] idx;
      idx = 3'd0;
      if (lsb_first) begin
         for (int k = 7; k >= 0; k--)
            if (v[k]) idx = k[2:0];
      end else begin
         for (int k = 0; k < 8; k++)
            if (v[k]) idx = k[2:0];
      end
      return idx;
   endfunction

   logic [7:0] pend_p0;
   logic [2:0] code_p0;
   logic       vld_p0;

   logic [7:0] cand;
   logic [7:0] grant;
   logic [2:0] idx;
   logic       load;

   always_comb begin
      cand  = pend_p0 | (EN ? D : 8'h00);
      idx   = sel_index(cand, LSB_FIRST);
      grant = (cand != 8'h00) ? (8'h01 << idx) : 8'h00;
      load  = !vld_p0 || READY;
   end

   // Output stage: the code register reloads only when empty or being accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_p0 <= 8'h00;
         code_p0 <= 3'd0;
         vld_p0  <= 1'b0;
      end else if (load) begin
         if (cand != 8'h00) begin
            code_p0 <= idx;
            vld_p0  <= 1'b1;
            pend_p0 <= cand & ~grant;
         end else begin
            vld_p0  <= 1'b0;
            pend_p0 <= 8'h00;
         end
      end else begin
         pend_p0 <= cand;
      end
   end

   assign {A, B, C} = code_p0;
   assign VALID     = vld_p0;
   assign PEND      = pend_p0;
   assign EMPTY     = (pend_p0 == 8'h00) && !vld_p0;

endmodule

// File: tb/tb_priority_encoder_8to3_reg.sv
// Directed bench for priority_encoder_8to3_reg: one MSB-first and one LSB-first
// instance share stimulus; expected values are hand-derived per step.
module tb_priority_encoder_8to3_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       EN;
   logic [7:0] D;
   logic       READY;

   logic       a0, b0, c0, valid0, empty0;
   logic [7:0] pend0;
   logic       a1, b1, c1, valid1, empty1;
   logic [7:0] pend1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   priority_encoder_8to3_reg #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .EN(EN), .D(D), .READY(READY),
      .A(a0), .B(b0), .C(c0), .VALID(valid0), .PEND(pend0), .EMPTY(empty0)
   );

   priority_encoder_8to3_reg #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst(rst), .EN(EN), .D(D), .READY(READY),
      .A(a1), .B(b1), .C(c1), .VALID(valid1), .PEND(pend1), .EMPTY(empty1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks the MSB-first instance's full visible state.
   task automatic chk0(input string tag, input logic v, input logic [2:0] abc,
                       input logic [7:0] p, input logic e);
      check({tag, ".valid"}, {31'd0, valid0}, {31'd0, v});
      check({tag, ".abc"},   {29'd0, a0, b0, c0}, {29'd0, abc});
      check({tag, ".pend"},  {24'd0, pend0}, {24'd0, p});
      check({tag, ".empty"}, {31'd0, empty0}, {31'd0, e});
   endtask

   task automatic chk1(input string tag, input logic v, input logic [2:0] abc,
                       input logic [7:0] p);
      check({tag, ".valid"}, {31'd0, valid1}, {31'd0, v});
      check({tag, ".abc"},   {29'd0, a1, b1, c1}, {29'd0, abc});
      check({tag, ".pend"},  {24'd0, pend1}, {24'd0, p});
   endtask

   initial begin
      // Reset dominance: D=FF with EN=1 must not be captured.
      rst = 1'b1; EN = 1'b1; D = 8'hFF; READY = 1'b0;
      step(); step();
      rst = 1'b0; EN = 1'b0; D = 8'h00;
      chk0("rst", 1'b0, 3'b000, 8'h00, 1'b1);
      chk1("rst_l", 1'b0, 3'b000, 8'h00);
      step();
      chk0("rst_idle", 1'b0, 3'b000, 8'h00, 1'b1);

      // Priority drain of 8'h24 on both instances.
      READY = 1'b1; EN = 1'b1; D = 8'h24;
      step();
      EN = 1'b0; D = 8'h00;
      chk0("drain1", 1'b1, 3'b101, 8'h04, 1'b0);
      chk1("drain1_l", 1'b1, 3'b010, 8'h20);
      step();
      chk0("drain2", 1'b1, 3'b010, 8'h00, 1'b0);
      chk1("drain2_l", 1'b1, 3'b101, 8'h00);
      step();
      chk0("drain3", 1'b0, 3'b010, 8'h00, 1'b1);
      chk1("drain3_l", 1'b0, 3'b101, 8'h00);

      // Backpressure: code 7 held while 0 accumulates.
      READY = 1'b0; EN = 1'b1; D = 8'h80;
      step();
      chk0("bp1", 1'b1, 3'b111, 8'h00, 1'b0);
      D = 8'h01;
      step();
      chk0("bp2", 1'b1, 3'b111, 8'h01, 1'b0);
      EN = 1'b0; D = 8'h00;
      step();
      chk0("bp3", 1'b1, 3'b111, 8'h01, 1'b0);
      READY = 1'b1;
      step();
      chk0("bp4", 1'b1, 3'b000, 8'h00, 1'b0);
      step();
      chk0("bp5", 1'b0, 3'b000, 8'h00, 1'b1);

      // Re-request in the grant cycle merges into one code 3.
      READY = 1'b0; EN = 1'b1; D = 8'h80;
      step();
      D = 8'h08;
      step();
      chk0("rr_pend", 1'b1, 3'b111, 8'h08, 1'b0);
      READY = 1'b1;
      step();
      chk0("rr_grant", 1'b1, 3'b011, 8'h00, 1'b0);
      EN = 1'b0; D = 8'h00;
      step();
      chk0("rr_single", 1'b0, 3'b011, 8'h00, 1'b1);

      // Re-request one cycle after the grant gives a second code 3.
      READY = 1'b0; EN = 1'b1; D = 8'h80;
      step();
      D = 8'h08;
      step();
      READY = 1'b1;
      step();
      chk0("rr2_grant", 1'b1, 3'b011, 8'h00, 1'b0);
      step();
      chk0("rr2_second", 1'b1, 3'b011, 8'h00, 1'b0);
      EN = 1'b0; D = 8'h00;
      step();
      chk0("rr2_done", 1'b0, 3'b011, 8'h00, 1'b1);

      // EN gating: D=FF ignored while a code is held.
      READY = 1'b0; EN = 1'b1; D = 8'h10;
      step();
      chk0("en_load", 1'b1, 3'b100, 8'h00, 1'b0);
      EN = 1'b0; D = 8'hFF;
      step(); step();
      chk0("en_gate", 1'b1, 3'b100, 8'h00, 1'b0);
      READY = 1'b1;
      step();
      chk0("en_drain", 1'b0, 3'b100, 8'h00, 1'b1);

      // Reset mid-operation discards held code and pending requests.
      READY = 1'b0; EN = 1'b1; D = 8'h02;
      step();
      D = 8'hF0;
      step();
      chk0("mid_pre", 1'b1, 3'b001, 8'hF0, 1'b0);
      rst = 1'b1; EN = 1'b0; D = 8'h00;
      step();
      rst = 1'b0;
      chk0("mid_rst", 1'b0, 3'b000, 8'h00, 1'b1);
      READY = 1'b1;
      step();
      chk0("mid_after1", 1'b0, 3'b000, 8'h00, 1'b1);
      step();
      chk0("mid_after2", 1'b0, 3'b000, 8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
